// File: rtl/fault_msg_scheduler.sv
// rtl/fault_msg_scheduler.sv - fault message intake over req/ack, IFM/PBM queues, PBM-first release
// Holds the per-class circular FIFO and the scheduler top that feeds two of them.

module fmsg_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           data_i,
  output logic [W-1:0]           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rptr_q;
  logic [PW-1:0] wptr_q;
  logic [CW-1:0] count_q;

  // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PW'(1);
      if (pop_i)  rptr_q <= rptr_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_i) mem_q[wptr_q] <= data_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
endmodule

module fault_msg_scheduler #(
  parameter int DEPTH  = 4,
  parameter int CODE_W = 4
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   in_req,
  input  logic [CODE_W-1:0]      in_code,
  output logic                   in_ack,
  output logic                   out_valid,
  output logic [CODE_W-1:0]      out_code,
  output logic                   out_is_pbm,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] ifm_count,
  output logic [$clog2(DEPTH):0] pbm_count,
  output logic [2:0]             ifm_led,
  output logic                   ovf_pulse,
  output logic                   ill_pulse
);
  typedef enum logic [1:0] {IDLE, ACKH, ACKL} state_t;

  state_t            state_q;
  logic              req_meta_q;
  logic              rs_q;
  logic              in_ack_q;
  logic              ovf_q;
  logic              ill_q;
  logic [2:0]        led_q;
  logic [2:0]        led_d;

  logic              is_ifm;
  logic              is_pbm;
  logic [2:0]        led_set;
  logic              capture;
  logic              ifm_full;
  logic              pbm_full;
  logic              ifm_nonempty;
  logic              pbm_nonempty;
  logic              pop_ifm;
  logic              pop_pbm;
  logic              ifm_push;
  logic              pbm_push;
  logic              ifm_drop;
  logic              pbm_drop;
  logic [CODE_W-1:0] ifm_head;
  logic [CODE_W-1:0] pbm_head;

  always_comb begin
    is_ifm  = 1'b0;
    is_pbm  = 1'b0;
    led_set = 3'b000;
    case (in_code)
      CODE_W'(1): begin is_ifm = 1'b1; led_set = 3'b001; end
      CODE_W'(4): begin is_ifm = 1'b1; led_set = 3'b010; end
      CODE_W'(5): begin is_ifm = 1'b1; led_set = 3'b100; end
      CODE_W'(2), CODE_W'(3), CODE_W'(6), CODE_W'(7): is_pbm = 1'b1;
      default: ;
    endcase
  end

  assign capture      = (state_q == IDLE) && rs_q;
  assign ifm_nonempty = (ifm_count != '0);
  assign pbm_nonempty = (pbm_count != '0);
  assign pop_pbm      = out_ready && pbm_nonempty;
  assign pop_ifm      = out_ready && !pbm_nonempty && ifm_nonempty;

  // A full queue still accepts a push when it is popped in the same cycle
  assign ifm_push = capture && is_ifm && (!ifm_full || pop_ifm);
  assign pbm_push = capture && is_pbm && (!pbm_full || pop_pbm);
  assign ifm_drop = capture && is_ifm && ifm_full && !pop_ifm;
  assign pbm_drop = capture && is_pbm && pbm_full && !pop_pbm;
  assign led_d    = ifm_push ? (led_q | led_set) : led_q;

  fmsg_fifo #(.DEPTH(DEPTH), .W(CODE_W)) u_ifm (
    .clock   (clock),
    .rst     (rst),
    .push_i  (ifm_push),
    .pop_i   (pop_ifm),
    .data_i  (in_code),
    .head_o  (ifm_head),
    .count_o (ifm_count),
    .full_o  (ifm_full)
  );

  fmsg_fifo #(.DEPTH(DEPTH), .W(CODE_W)) u_pbm (
    .clock   (clock),
    .rst     (rst),
    .push_i  (pbm_push),
    .pop_i   (pop_pbm),
    .data_i  (in_code),
    .head_o  (pbm_head),
    .count_o (pbm_count),
    .full_o  (pbm_full)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      req_meta_q <= 1'b0;
      rs_q       <= 1'b0;
      state_q    <= IDLE;
      in_ack_q   <= 1'b0;
      ovf_q      <= 1'b0;
      ill_q      <= 1'b0;
      led_q      <= 3'b000;
    end else begin
      req_meta_q <= in_req;
      rs_q       <= req_meta_q;
      ovf_q      <= ifm_drop || pbm_drop;
      ill_q      <= capture && !is_ifm && !is_pbm;
      led_q      <= led_d;
      case (state_q)
        IDLE: if (rs_q) begin
          in_ack_q <= 1'b1;
          state_q  <= ACKH;
        end
        ACKH: if (!rs_q) begin
          in_ack_q <= 1'b0;
          state_q  <= ACKL;
        end
        ACKL:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ack     = in_ack_q;
  assign ovf_pulse  = ovf_q;
  assign ill_pulse  = ill_q;
  assign ifm_led    = led_q;
  assign out_valid  = pbm_nonempty || ifm_nonempty;
  assign out_is_pbm = pbm_nonempty;
  assign out_code   = pbm_nonempty ? pbm_head : (ifm_nonempty ? ifm_head : '0);
endmodule

// File: tb/tb_fault_msg_scheduler.sv
// tb/tb_fault_msg_scheduler.sv - scenario tasks plus randomized run against a queue reference model
module tb_fault_msg_scheduler;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_req = 1'b0;
  logic [3:0] in_code = 4'd0;
  logic       out_ready = 1'b0;
  logic       in_ack, out_valid, out_is_pbm, ovf_pulse, ill_pulse;
  logic [3:0] out_code;
  logic [2:0] ifm_count, pbm_count, ifm_led;

  int vectors = 0;
  int miscompares = 0;

  fault_msg_scheduler #(.DEPTH(DEPTH), .CODE_W(4)) dut (
    .clock      (clk),
    .rst        (rst),
    .in_req     (in_req),
    .in_code    (in_code),
    .in_ack     (in_ack),
    .out_valid  (out_valid),
    .out_code   (out_code),
    .out_is_pbm (out_is_pbm),
    .out_ready  (out_ready),
    .ifm_count  (ifm_count),
    .pbm_count  (pbm_count),
    .ifm_led    (ifm_led),
    .ovf_pulse  (ovf_pulse),
    .ill_pulse  (ill_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: two plain queues, updated at the edge the stimulus declares as the capture edge
  logic [3:0] m_ifm[$];
  logic [3:0] m_pbm[$];
  logic [2:0] m_led = 3'b000;
  logic       m_ovf = 1'b0;
  logic       m_ill = 1'b0;
  bit         cap_flag = 1'b0;
  logic [3:0] cap_code = 4'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ifm.delete();
      m_pbm.delete();
      m_led <= 3'b000;
      m_ovf <= 1'b0;
      m_ill <= 1'b0;
    end else begin
      m_ovf <= 1'b0;
      m_ill <= 1'b0;
      if (out_ready) begin
        if (m_pbm.size() > 0) void'(m_pbm.pop_front());
        else if (m_ifm.size() > 0) void'(m_ifm.pop_front());
      end
      if (cap_flag) begin
        if (cap_code == 4'd1 || cap_code == 4'd4 || cap_code == 4'd5) begin
          if (m_ifm.size() >= DEPTH) m_ovf <= 1'b1;
          else begin
            m_ifm.push_back(cap_code);
            m_led <= m_led | ((cap_code == 4'd1) ? 3'b001 : (cap_code == 4'd4) ? 3'b010 : 3'b100);
          end
        end else if (cap_code == 4'd2 || cap_code == 4'd3 || cap_code == 4'd6 || cap_code == 4'd7) begin
          if (m_pbm.size() >= DEPTH) m_ovf <= 1'b1;
          else m_pbm.push_back(cap_code);
        end else begin
          m_ill <= 1'b1;
        end
      end
    end
  end

  // rdy_mode: 0 leave out_ready alone, 1 randomize each cycle, 2 assert only for the capture edge
  task automatic hs(input logic [3:0] code, input int rdy_mode, output logic ovf_seen, output logic ill_seen);
    ovf_seen = 1'b0;
    ill_seen = 1'b0;
    in_code = code;
    in_req = 1'b1;
    if (rdy_mode == 1) out_ready = ($urandom_range(3) == 0);
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      if (rdy_mode == 1) out_ready = ($urandom_range(3) == 0);
      case (n)
        2: begin
          vectors++;
          if (in_ack !== 1'b0) begin miscompares++; $display("FAIL ack_early code=%h: in_ack=%b expected 0", code, in_ack); end
          cap_flag = 1'b1;
          cap_code = code;
          if (rdy_mode == 2) out_ready = 1'b1;
        end
        3: begin
          cap_flag = 1'b0;
          if (rdy_mode == 2) out_ready = 1'b0;
          vectors++;
          if (in_ack !== 1'b1) begin miscompares++; $display("FAIL ack_rise code=%h: in_ack=%b expected 1", code, in_ack); end
          ovf_seen = ovf_pulse;
          ill_seen = ill_pulse;
          in_req = 1'b0;
        end
        5: begin
          vectors++;
          if (in_ack !== 1'b1) begin miscompares++; $display("FAIL ack_hold code=%h: in_ack=%b expected 1", code, in_ack); end
        end
        6: begin
          vectors++;
          if (in_ack !== 1'b0) begin miscompares++; $display("FAIL ack_fall code=%h: in_ack=%b expected 0", code, in_ack); end
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    in_req = 1'b0;
    out_ready = 1'b0;
    cap_flag = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({in_ack, out_valid, out_code, out_is_pbm} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_out: ack=%b valid=%b code=%h pbm=%b expected all 0", in_ack, out_valid, out_code, out_is_pbm);
    end
    vectors++;
    if ({ifm_count, pbm_count, ifm_led, ovf_pulse, ill_pulse} !== 11'b0) begin
      miscompares++;
      $display("FAIL reset_status: ifm=%0d pbm=%0d led=%b ovf=%b ill=%b expected all 0", ifm_count, pbm_count, ifm_led, ovf_pulse, ill_pulse);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic o, i;
    test_reset();
    hs(4'd1, 0, o, i);
    vectors++;
    if (ifm_count !== 3'd1 || out_valid !== 1'b1 || out_code !== 4'd1 || out_is_pbm !== 1'b0) begin
      miscompares++;
      $display("FAIL single_head: cnt=%0d valid=%b code=%h pbm=%b expected 1 1 1 0", ifm_count, out_valid, out_code, out_is_pbm);
    end
    vectors++;
    if (ifm_led !== 3'b001) begin miscompares++; $display("FAIL single_led: led=%b expected 001", ifm_led); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_pop: valid=%b expected 0", out_valid); end
  endtask

  task automatic test_illegal();
    logic o, i;
    hs(4'hF, 0, o, i);
    vectors++;
    if (i !== 1'b1 || o !== 1'b0) begin miscompares++; $display("FAIL illegal_pulse: ill=%b ovf=%b expected 1 0", i, o); end
    vectors++;
    if (ifm_count !== 3'd0 || pbm_count !== 3'd0 || ifm_led !== 3'b001) begin
      miscompares++;
      $display("FAIL illegal_state: ifm=%0d pbm=%0d led=%b expected 0 0 001", ifm_count, pbm_count, ifm_led);
    end
  endtask

  task automatic test_priority();
    logic o, i;
    logic [3:0] exp_code[3];
    logic       exp_pbm[3];
    exp_code[0] = 4'd3; exp_code[1] = 4'd4; exp_code[2] = 4'd5;
    exp_pbm[0] = 1'b1;  exp_pbm[1] = 1'b0;  exp_pbm[2] = 1'b0;
    test_reset();
    hs(4'd4, 0, o, i);
    hs(4'd3, 0, o, i);
    hs(4'd5, 0, o, i);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_code !== exp_code[k] || out_is_pbm !== exp_pbm[k]) begin
        miscompares++;
        $display("FAIL prio_pop%0d: valid=%b code=%h pbm=%b expected 1 %h %b", k, out_valid, out_code, out_is_pbm, exp_code[k], exp_pbm[k]);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || ifm_led !== 3'b110) begin
      miscompares++;
      $display("FAIL prio_end: valid=%b led=%b expected 0 110", out_valid, ifm_led);
    end
  endtask

  task automatic test_overflow();
    logic o, i;
    logic [3:0] codes[5];
    logic [3:0] exp1[4];
    logic [3:0] exp2[4];
    codes[0] = 4'd2; codes[1] = 4'd6; codes[2] = 4'd7; codes[3] = 4'd3; codes[4] = 4'd2;
    exp1[0] = 4'd2; exp1[1] = 4'd6; exp1[2] = 4'd7; exp1[3] = 4'd3;
    exp2[0] = 4'd6; exp2[1] = 4'd7; exp2[2] = 4'd3; exp2[3] = 4'd7;
    test_reset();
    for (int k = 0; k < 5; k++) begin
      hs(codes[k], 0, o, i);
      vectors++;
      if (o !== (k == 4)) begin miscompares++; $display("FAIL ovf_push%0d: ovf=%b expected %b", k, o, (k == 4)); end
    end
    vectors++;
    if (pbm_count !== 3'd4) begin miscompares++; $display("FAIL ovf_count: pbm=%0d expected 4", pbm_count); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (out_code !== exp1[k] || out_is_pbm !== 1'b1) begin
        miscompares++;
        $display("FAIL ovf_pop%0d: code=%h pbm=%b expected %h 1", k, out_code, out_is_pbm, exp1[k]);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) hs(codes[k], 0, o, i);
    hs(4'd7, 2, o, i);
    vectors++;
    if (o !== 1'b0 || pbm_count !== 3'd4) begin
      miscompares++;
      $display("FAIL full_pushpop: ovf=%b pbm=%0d expected 0 4", o, pbm_count);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (out_code !== exp2[k]) begin miscompares++; $display("FAIL full_pop%0d: code=%h expected %h", k, out_code, exp2[k]); end
      @(negedge clk);
    end
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL full_drain: valid=%b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    logic o, i;
    test_reset();
    hs(4'd1, 0, o, i);
    hs(4'd4, 0, o, i);
    vectors++;
    if (ifm_count !== 3'd2) begin miscompares++; $display("FAIL mid_pre: ifm=%0d expected 2", ifm_count); end
    in_code = 4'd5;
    in_req = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (in_ack !== 1'b1) begin miscompares++; $display("FAIL mid_ackh: in_ack=%b expected 1", in_ack); end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (in_ack !== 1'b0 || ifm_count !== 3'd0 || pbm_count !== 3'd0 || ifm_led !== 3'b000) begin
      miscompares++;
      $display("FAIL mid_async: ack=%b ifm=%0d pbm=%0d led=%b expected 0 0 0 000", in_ack, ifm_count, pbm_count, ifm_led);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (in_ack !== 1'b0) begin miscompares++; $display("FAIL mid_early: in_ack=%b expected 0", in_ack); end
    cap_flag = 1'b1;
    cap_code = 4'd5;
    @(negedge clk);
    cap_flag = 1'b0;
    vectors++;
    if (in_ack !== 1'b1 || ifm_count !== 3'd1 || out_code !== 4'd5 || ifm_led !== 3'b100) begin
      miscompares++;
      $display("FAIL mid_recapture: ack=%b ifm=%0d code=%h led=%b expected 1 1 5 100", in_ack, ifm_count, out_code, ifm_led);
    end
    in_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random();
    logic o, i;
    logic [3:0] legal[7];
    bit done;
    legal[0] = 4'd1; legal[1] = 4'd4; legal[2] = 4'd5; legal[3] = 4'd2;
    legal[4] = 4'd3; legal[5] = 4'd6; legal[6] = 4'd7;
    done = 1'b0;
    test_reset();
    fork
      begin
        for (int k = 0; k < 20; k++) hs(legal[$urandom_range(6)], 1, o, i);
        out_ready = 1'b1;
        repeat (12) @(negedge clk);
        out_ready = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          logic [3:0] e_code;
          logic       e_valid, e_pbm;
          @(negedge clk);
          #1;
          e_valid = (m_pbm.size() > 0) || (m_ifm.size() > 0);
          e_pbm = (m_pbm.size() > 0);
          e_code = (m_pbm.size() > 0) ? m_pbm[0] : (m_ifm.size() > 0) ? m_ifm[0] : 4'd0;
          vectors++;
          if (out_valid !== e_valid || out_code !== e_code || out_is_pbm !== e_pbm) begin
            miscompares++;
            $display("FAIL rnd_head @%0t: valid=%b code=%h pbm=%b expected %b %h %b", $time, out_valid, out_code, out_is_pbm, e_valid, e_code, e_pbm);
          end
          vectors++;
          if (ifm_count !== 3'(m_ifm.size()) || pbm_count !== 3'(m_pbm.size()) || ifm_led !== m_led || ovf_pulse !== m_ovf || ill_pulse !== m_ill) begin
            miscompares++;
            $display("FAIL rnd_status @%0t: ifm=%0d pbm=%0d led=%b ovf=%b ill=%b expected %0d %0d %b %b %b", $time,
                     ifm_count, pbm_count, ifm_led, ovf_pulse, ill_pulse, m_ifm.size(), m_pbm.size(), m_led, m_ovf, m_ill);
          end
        end
      end
    join
  endtask

  initial begin
    test_reset();
    test_single();
    test_illegal();
    test_priority();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fault_msg_scheduler.md
# fault_msg_scheduler

Buffers and orders the encoded fault messages produced by the UART receive path before the path-planning controller consumes them. Messages arrive through a 4-phase req/ack handshake from the receive domain and are sorted into an IFM (unit-fault) queue and a PBM (block-pickup) queue. A valid/ready port then releases them one at a time, with PBM strictly ahead of IFM. The block also drives the sticky per-unit IFM indicator LEDs and exposes occupancy and error status.

## Interface
- `DEPTH`, 4: entries per queue (power of two, 2..16).
- `CODE_W`, 4: message code width.
- `clock` in 1: single system clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_req` in 1: request from the receive domain; asynchronous, synchronized internally.
- `in_code` in CODE_W: message code; stable from `in_req` rise until `in_ack` rise.
- `in_ack` out 1: handshake acknowledge.
- `out_valid` out 1: a message is available.
- `out_code` out CODE_W: head message code.
- `out_is_pbm` out 1: head message is a PBM.
- `out_ready` in 1: consumer accepts the head this cycle.
- `ifm_count`, `pbm_count` out clog2(DEPTH)+1: queue occupancy.
- `ifm_led` out 3: sticky flags, bit0 = EU (0001), bit1 = RU (0100), bit2 = CU (0101).
- `ovf_pulse` out 1: one-cycle pulse when a message is dropped because its queue is full.
- `ill_pulse` out 1: one-cycle pulse when a message is dropped because its code is illegal.

## Operation
- Classification:
  - IFM codes are 0001, 0100 and 0101.
  - PBM codes are 0010, 0011, 0110 and 0111.
  - Every other code is illegal. An illegal message is acknowledged and then dropped, with `ill_pulse` asserted.
- Input FSM, states IDLE, ACKH and ACKL. `in_req` passes through a 2-flop synchronizer and the synchronized value is called `rs`.
  - IDLE: if `rs` is 1, capture `in_code` and classify it, set `in_ack` to 1, then go to ACKH.
  - ACKH: hold `in_ack` at 1 while `rs` is 1. When `rs` is 0, set `in_ack` to 0 and go to ACKL.
  - ACKL: go to IDLE unconditionally. This state guarantees at least one cycle with `in_ack` low before the next capture.
  - One message is captured per handshake. `in_code` is sampled only in the IDLE capture cycle.
- Queues: two independent circular FIFOs with read pointer, write pointer and count; both pointers wrap modulo DEPTH.
  - Push happens in the capture cycle.
  - Pop happens when `out_valid` and `out_ready` are both 1.
  - Push to a full queue with no same-cycle pop on that queue drops the message. The queue is unchanged and `ovf_pulse` is asserted.
  - Push and pop on the same queue in the same cycle: both take effect and the count is unchanged. This applies even when the queue is full.
- Arbitration:
  - If `pbm_count` is not 0, the head is the PBM queue head and `out_is_pbm` is 1.
  - Otherwise, if `ifm_count` is not 0, the head is the IFM queue head and `out_is_pbm` is 0.
  - Otherwise `out_valid` is 0 and `out_code` is 0.
  - `out_valid`, `out_code` and `out_is_pbm` are combinational from registered queue state only; there is no path from `in_*` to them.
  - A PBM pushed in cycle N overtakes an IFM head from cycle N+1 onward. The cycle-N pop still takes the old head.
- `ifm_led`: the matching bit sets when an IFM code is pushed (not when dropped). Bits clear only on reset.

## Timing
- Reset values:
  - `in_ack` 0, FSM in IDLE, synchronizer flops 0.
  - Both queues empty, both counts 0.
  - `out_valid` 0, `out_code` 0, `out_is_pbm` 0.
  - `ifm_led` 000, `ovf_pulse` 0, `ill_pulse` 0.
- Reset asserted mid-handshake: `in_ack` drops immediately, asynchronously. After release, a still-high `in_req` is treated as a new request.
- Latency:
  - `in_req` high before edge E0 gives `rs` = 1 after edge E1.
  - Capture occurs at edge E2: the count and `in_ack` update after E2, and `out_valid` is visible in the cycle after E2.
- Release:
  - `in_req` low before edge F0 gives `in_ack` = 0 after F2.
  - The earliest next capture is F4.
- `ovf_pulse` and `ill_pulse` are registered and assert for the single cycle after the capture edge.
- Throughput: one pop per cycle. Input is limited by the handshake to one message per 5 or more cycles.

## Test plan
- Reset, then a single handshake with code 0001:
  - `in_ack` rises 2 cycles after `in_req`.
  - `ifm_count` becomes 1; `out_code` is 0001 and `out_is_pbm` is 0.
  - `ifm_led` becomes 001.
  - Pop with `out_ready` set: `out_valid` goes to 0.
- Push IFM 0100, then PBM 0011, then IFM 0101, all with `out_ready` at 0. Then hold `out_ready` at 1.
  - Pops occur in the order 0011, 0100, 0101; `out_is_pbm` reads 1, 0, 0.
  - `ifm_led` ends at 110.
- Push 5 PBM codes (0010, 0110, 0111, 0011, 0010) with `out_ready` at 0 and DEPTH = 4.
  - The 5th push gives a single `ovf_pulse`; `pbm_count` stays at 4.
  - Pops return 0010, 0110, 0111, 0011.
- With the PBM queue full, hold `out_ready` at 1 during the capture cycle of a 6th PBM 0111.
  - No overflow: `pbm_count` stays at 4 and 0111 is last in the pop order.
- Handshake with code 1111:
  - `in_ack` completes normally and `ill_pulse` asserts.
  - Both counts stay 0 and `ifm_led` is unchanged.
- Assert `rst` while in ACKH with 2 IFMs queued:
  - `in_ack` goes to 0 immediately, both counts go to 0 and `ifm_led` goes to 000.
  - `in_req` still high after release causes a fresh capture 2 cycles later.
- Run 20 random legal messages with random `out_ready` against a reference model:
  - Every pop matches the model.
  - Order is correct through multiple pointer wraps.
